// File: rtl/ddr_wr_pkg.sv
// Shared definitions for the DDR burst writer: FIFO word field positions,
// default burst length and the writer FSM state type.
package ddr_wr_pkg;

  localparam int DATA_LSB      = 0;
  localparam int ADDR_LSB      = 64;
  localparam int VALID_BIT     = 93;
  localparam int EOF_BIT       = 94;
  localparam int LAST_BIT      = 95;

  localparam int DATA_W        = 64;
  localparam int ADDR_W        = 29;
  localparam int BURST_LEN_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/ddr_burst_writer_if.sv
// Avalon-MM burst write bus between the burst writer (master) and the DDR
// controller slave port.
interface ddr_burst_writer_if;
  import ddr_wr_pkg::*;

  // Handshake: a beat transfers on any cycle where avl_write is high and
  // avl_waitrequest is low; while stalled the master holds address, burstcount
  // and writedata unchanged.
  logic [ADDR_W-1:0] avl_address;
  logic [6:0]        avl_burstcount;
  logic              avl_beginbursttransfer;
  logic              avl_write;
  logic [DATA_W-1:0] avl_writedata;
  logic [7:0]        avl_byteenable;
  logic              avl_waitrequest;

  modport master (
    output avl_address, avl_burstcount, avl_beginbursttransfer,
           avl_write, avl_writedata, avl_byteenable,
    input  avl_waitrequest
  );

  modport slave (
    input  avl_address, avl_burstcount, avl_beginbursttransfer,
           avl_write, avl_writedata, avl_byteenable,
    output avl_waitrequest
  );

endinterface

// File: rtl/ddr_burst_frame_checker.sv
// Sticky framing-error flag for burst writes; only instantiated when the
// DDR_WR_CHECK_EN macro is defined.
module ddr_burst_frame_checker
  import ddr_wr_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic       clk_100,
  input  logic       reset_n,
  input  logic       beat_acc,
  input  logic [5:0] beat_cnt,
  input  logic [2:0] flags,       // {last, eof, valid}
  input  logic       start_frame,
  output logic       burst_err
);

  localparam logic [5:0] LAST_BEAT = 6'(BURST_LEN - 1);

  logic is_last_beat;
  logic err_now;
  logic unused_eof;

  assign unused_eof   = flags[1];
  assign is_last_beat = (beat_cnt == LAST_BEAT);
  // Last flag must appear on the final beat and nowhere else.
  assign err_now      = beat_acc & (~flags[0] | (flags[2] ^ is_last_beat));

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      burst_err <= 1'b0;
    end else if (err_now) begin
      burst_err <= 1'b1;
    end else if (start_frame) begin
      burst_err <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_burst_writer.sv
// Drains the packed frame FIFO into fixed-length Avalon-MM write bursts.
// Define DDR_WR_CHECK_EN to compile in the framing checks driving burst_err.
module ddr_burst_writer
  import ddr_wr_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int USEDW_W   = 10
) (
  input  logic               clk_100,
  input  logic               reset_n,
  input  logic               start_frame,
  input  logic [95:0]        fifo_q,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  ddr_burst_writer_if.master avl,
  output logic               frame_done,
  output logic               burst_err,
  output logic               busy,
  output state_t             dbg_state
);

  localparam logic [USEDW_W-1:0] START_LEVEL = USEDW_W'(BURST_LEN);
  localparam logic [5:0]         LAST_BEAT   = 6'(BURST_LEN - 1);

  state_t            state;
  logic              begin_r;
  logic              eof_seen;
  logic              frame_done_r;
  logic [5:0]        beat_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic              beat_acc;
  logic              last_beat;

  assign avl.avl_write              = (state == BURST) & ~fifo_empty;
  assign avl.avl_writedata          = fifo_q[DATA_LSB +: DATA_W];
  assign avl.avl_address            = addr_r;
  assign avl.avl_burstcount         = 7'(BURST_LEN);
  assign avl.avl_byteenable         = 8'hFF;
  assign avl.avl_beginbursttransfer = begin_r;

  assign beat_acc   = avl.avl_write & ~avl.avl_waitrequest;
  assign last_beat  = beat_acc & (beat_cnt == LAST_BEAT);
  assign fifo_rdreq = beat_acc;
  assign frame_done = frame_done_r;
  assign busy       = (state == BURST);
  assign dbg_state  = state;

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      begin_r      <= 1'b0;
      eof_seen     <= 1'b0;
      frame_done_r <= 1'b0;
      beat_cnt     <= 6'd0;
      addr_r       <= '0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        IDLE: begin
          // Address comes from the head word, which is the first beat.
          if (fifo_usedw >= START_LEVEL) begin
            state    <= BURST;
            addr_r   <= fifo_q[ADDR_LSB +: ADDR_W];
            begin_r  <= 1'b1;
            beat_cnt <= 6'd0;
            eof_seen <= 1'b0;
          end
        end
        BURST: begin
          begin_r <= 1'b0;
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 6'd1;
            if (fifo_q[EOF_BIT]) eof_seen <= 1'b1;
            if (last_beat) begin
              state        <= IDLE;
              frame_done_r <= eof_seen | fifo_q[EOF_BIT];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_WR_CHECK_EN
  ddr_burst_frame_checker #(.BURST_LEN(BURST_LEN)) u_checker (
    .clk_100     (clk_100),
    .reset_n     (reset_n),
    .beat_acc    (beat_acc),
    .beat_cnt    (beat_cnt),
    .flags       (fifo_q[LAST_BIT:VALID_BIT]),
    .start_frame (start_frame),
    .burst_err   (burst_err)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{start_frame, fifo_q[LAST_BIT], fifo_q[VALID_BIT]};
  assign burst_err  = 1'b0;
`endif

endmodule

// File: doc/ddr_burst_writer.md
# ddr_burst_writer

Drains the 96-bit frame FIFO loaded by the frame-buffer write packer and issues fixed-length Avalon-MM write bursts to the DDR SDRAM controller. It sits between that FIFO's show-ahead read port and the controller's Avalon-MM slave. Each 32-word burst takes its address from the packed address field of its first word. The block also reports end-of-frame completion and framing errors.

## Interface
Parameters:
- BURST_LEN, 32: words per burst; must match the packer's burst size.
- USEDW_W, 10: width of the FIFO fill-level input.

Ports (reset reset_n, asynchronous, active-low; clock clk_100):
- clk_100  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- start_frame  in  1  frame-start pulse; clears burst_err
- fifo_q  in  96  show-ahead word: [63:0] data, [92:64] address, [93] valid, [94] end_write_buf, [95] last_unit_burst
- fifo_empty  in  1  FIFO empty
- fifo_usedw  in  USEDW_W  FIFO fill level
- fifo_rdreq  out  1  pop; asserted when a beat is accepted
- avl_address  out  29  burst word address
- avl_burstcount  out  7  constant BURST_LEN
- avl_beginbursttransfer  out  1  first cycle of each burst
- avl_write  out  1  write strobe
- avl_writedata  out  64  fifo_q[63:0]
- avl_byteenable  out  8  constant 8'hFF
- avl_waitrequest  in  1  slave stall
- frame_done  out  1  one-cycle pulse after the burst that carries end_write_buf completes
- burst_err  out  1  sticky framing error
- busy  out  1  state is BURST

## Operation
- FSM has two states, IDLE and BURST.
- IDLE to BURST: taken when fifo_usedw >= BURST_LEN. On the transition, latch avl_address from fifo_q[92:64], set begin_r, clear beat_cnt and eof_seen.
- In BURST:
  - avl_write = ~fifo_empty.
  - Beat accepted = avl_write & ~avl_waitrequest.
  - fifo_rdreq = beat accepted.
  - beat_cnt (6 bits) increments on each accepted beat.
- A beat with fifo_q[94] set causes eof_seen to be set.
- BURST to IDLE: taken on the accepted beat with beat_cnt == BURST_LEN-1. If eof_seen, or fifo_q[94] is set on that beat, frame_done pulses on the next cycle.
- There is always one IDLE cycle between bursts, so peak efficiency is 32/33.
- avl_address and avl_burstcount are held stable for the whole burst.
- Framing checks:
  - fifo_q[93] == 0 on any accepted beat sets burst_err.
  - fifo_q[95] == 1 on a beat other than beat 31 sets burst_err.
  - fifo_q[95] == 0 on beat 31 sets burst_err.
- A framing error does not abort the burst.
- burst_err is cleared by start_frame. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: all outputs 0 except avl_burstcount = BURST_LEN and avl_byteenable = 8'hFF. FSM resets to IDLE; beat_cnt, eof_seen and begin_r reset to 0.
- Latency:
  - The first avl_write occurs 1 cycle after fifo_usedw reaches BURST_LEN.
  - Data is combinational from fifo_q, so there is zero latency from FIFO head to bus.
- avl_beginbursttransfer is high exactly one cycle, the first BURST cycle, regardless of avl_waitrequest.
- While avl_waitrequest is high, writedata is held, no pop occurs and beat_cnt holds.
- If fifo_empty goes high mid-burst, avl_write drops and the burst resumes when data returns. No error is raised; this is legal Avalon behaviour.
- If reset_n is asserted mid-burst, the block returns immediately to IDLE. The controller side must be reset in the same domain.
- fifo_usedw equal to BURST_LEN-1 never starts a burst.

## Configuration
- DDR_WR_CHECK_EN defined: the framing checks above are compiled in, and burst_err behaves as specified.
- DDR_WR_CHECK_EN undefined: the check logic is omitted, burst_err is tied to 0, and fifo_q[95:93] are ignored.

## Structure
- Package ddr_wr_pkg holds:
  - FIFO field positions (DATA_LSB=0, ADDR_LSB=64, VALID_BIT=93, EOF_BIT=94, LAST_BIT=95)
  - BURST_LEN_DEF=32
  - the state enum {IDLE, BURST}
- One sub-module, ddr_burst_frame_checker, instantiated only under DDR_WR_CHECK_EN. It takes the beat-accept strobe, beat_cnt, fifo_q[95:93] and start_frame, and produces burst_err.

## Test plan
- **Single burst:** load 32 words, address 0x100, valid=1, last flag only on word 31 -> one begin pulse, avl_address=0x100, burstcount=32, 32 beats, 32 rdreq, busy falls, burst_err=0.
- **Waitrequest stall:** hold avl_waitrequest high for 3 cycles at beat 5 -> writedata is held and there is no rdreq during the stall; the burst still totals 32 beats.
- **Threshold:** fifo_usedw=31 held -> avl_write stays 0. Raise fifo_usedw to 32 -> the burst starts on the next cycle.
- **End of frame:** end_write_buf set on beat 31 of the second burst -> frame_done high for exactly one cycle after that beat; second burst address is 0x120.
- **Framing error (DDR_WR_CHECK_EN):** last flag missing on beat 31 -> burst_err=1 and stays 1 until a start_frame pulse clears it.
- **Reset mid-burst:** assert reset_n low at beat 10 -> all outputs return to reset values; the next burst starts cleanly from beat 0.
